// File: rtl/serial_pattern_detector.sv
// serial_pattern_detector: overlapping serial pattern matcher with a fill guard and saturating match counter.
module serial_pattern_detector #(
    parameter int PATTERN_WIDTH = 4,
    parameter logic [PATTERN_WIDTH-1:0] PATTERN = 4'b1011,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   bit_valid,
    input  logic                   bit_in,
    output logic                   match,
    output logic [COUNT_WIDTH-1:0] match_count,
    output logic                   count_sat,
    output logic                   armed
);
    localparam int FW = $clog2(PATTERN_WIDTH);
    localparam logic [FW-1:0] LAST = FW'(PATTERN_WIDTH - 1);
    typedef enum logic {FILLING, ARMED} state_t;
    state_t state, state_n;
    logic [FW-1:0] fill, fill_n;
    logic [PATTERN_WIDTH-1:0] hist, hist_n;
    logic [COUNT_WIDTH-1:0] count_n;
    logic hit;
    // FILL_k is FILLING with fill == k; the bit taken at fill == LAST completes the history
    always_comb begin
        hist_n  = {hist[PATTERN_WIDTH-2:0], bit_in};
        fill_n  = (bit_valid && state == FILLING && fill != LAST) ? fill + 1'b1 : fill;
        state_n = (bit_valid && fill == LAST) ? ARMED : state;
        hit     = bit_valid && (state == ARMED || fill == LAST) && hist_n == PATTERN;
        count_n = (hit && !count_sat) ? match_count + 1'b1 : match_count;
    end
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            hist        <= '0;
            state       <= FILLING;
            fill        <= '0;
            match       <= 1'b0;
            match_count <= '0;
            count_sat   <= 1'b0;
        end else begin
            if (bit_valid) hist <= hist_n;
            state       <= state_n;
            fill        <= fill_n;
            match       <= hit;
            match_count <= count_n;
            count_sat   <= &count_n;
        end
    end
    assign armed = state == ARMED;
endmodule

// File: tb/tb_serial_pattern_detector.sv
// tb_serial_pattern_detector: table-driven scoreboard bench over default, all-zero-pattern and 2-bit-counter builds.
module tb_serial_pattern_detector;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;
    logic [2:0] clr, vld, bin;
    logic m0, m1, m2, s0, s1, s2, a0, a1, a2;
    logic [7:0] n0, n1;
    logic [1:0] n2;
    int total = 0, passed = 0, step_no = 0;

    serial_pattern_detector dut0 (
        .clock(clk), .reset(rst), .clear(clr[0]), .bit_valid(vld[0]), .bit_in(bin[0]),
        .match(m0), .match_count(n0), .count_sat(s0), .armed(a0));
    serial_pattern_detector #(.PATTERN(4'b0000)) dut1 (
        .clock(clk), .reset(rst), .clear(clr[1]), .bit_valid(vld[1]), .bit_in(bin[1]),
        .match(m1), .match_count(n1), .count_sat(s1), .armed(a1));
    serial_pattern_detector #(.COUNT_WIDTH(2)) dut2 (
        .clock(clk), .reset(rst), .clear(clr[2]), .bit_valid(vld[2]), .bit_in(bin[2]),
        .match(m2), .match_count(n2), .count_sat(s2), .armed(a2));

    typedef struct {
        int d;
        logic r, c, v, b, m;
        logic [7:0] n;
        logic s, a;
    } vec_t;
    typedef struct {
        int d;
        logic m;
        logic [7:0] n;
        logic s, a;
    } exp_t;
    exp_t sb[$];
    vec_t tbl[$];

    function automatic vec_t mk(int d, logic r, logic c, logic v, logic b, logic m,
                                logic [7:0] n, logic s, logic a);
        vec_t x;
        x.d = d; x.r = r; x.c = c; x.v = v; x.b = b; x.m = m; x.n = n; x.s = s; x.a = a;
        return x;
    endfunction

    task automatic check(string what, logic [7:0] act, logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL step %0d %s: got %0d, expected %0d", step_no, what, act, exp);
    endtask

    task automatic step(int d, logic r, logic c, logic v, logic b, logic em,
                        logic [7:0] en, logic es, logic ea);
        exp_t e;
        exp_t x;
        logic am, as_, aa;
        logic [7:0] an;
        rst = r; clr = '0; vld = '0; bin = '0;
        clr[d] = c; vld[d] = v; bin[d] = v ? b : 1'bx;
        x.d = d; x.m = em; x.n = en; x.s = es; x.a = ea;
        sb.push_back(x);
        @(posedge clk);
        #1;
        step_no++;
        e = sb.pop_front();
        am = e.d == 0 ? m0 : e.d == 1 ? m1 : m2;
        an = e.d == 0 ? n0 : e.d == 1 ? n1 : {6'b0, n2};
        as_ = e.d == 0 ? s0 : e.d == 1 ? s1 : s2;
        aa = e.d == 0 ? a0 : e.d == 1 ? a1 : a2;
        check($sformatf("dut%0d match", e.d), {7'b0, am}, {7'b0, e.m});
        check($sformatf("dut%0d match_count", e.d), an, e.n);
        check($sformatf("dut%0d count_sat", e.d), {7'b0, as_}, {7'b0, e.s});
        check($sformatf("dut%0d armed", e.d), {7'b0, aa}, {7'b0, e.a});
    endtask

    initial begin
        logic [3:0] pat;
        pat = 4'b1011;
        // overlapping matches: 1011011 -> pulses after bits 4 and 7
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 2, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 2, 0, 1));
        // valid gaps with X data in between
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 1, 0, 1));
        // reset mid-pattern
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 1, 0, 1));
        // fill guard on the all-zero pattern
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 1, 1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 1, 0, 1, 2, 0, 1));
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 2, 0, 1));
        // saturation of a 2-bit counter over five 1011 patterns
        tbl.push_back(mk(2, 1, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 5; k++) begin
            int prev, cur;
            prev = k - 1 > 3 ? 3 : k - 1;
            cur = k > 3 ? 3 : k;
            for (int j = 0; j < 3; j++)
                tbl.push_back(mk(2, 0, 0, 1, pat[3-j], 0, 8'(prev), prev == 3, k > 1));
            tbl.push_back(mk(2, 0, 0, 1, pat[0], 1, 8'(cur), cur == 3, 1));
        end
        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i].d, tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].b, tbl[i].m, tbl[i].n, tbl[i].s, tbl[i].a);
        // clear colliding with a valid bit while armed with hist ending 101
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 1, 1, 0, 1);
        step(0, 0, 0, 1, 0, 0, 1, 0, 1);
        step(0, 0, 0, 1, 1, 0, 1, 0, 1);
        step(0, 0, 1, 1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 1, 1, 0, 1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
